alu_bist: RTL
=============

Name: alu_bist

Overview:
- Synthesizable built-in self-test controller for the Alu block; it is the stimulus-and-response end of the Alu interface.
- Drives pseudo-random Alu input vectors from a 32-bit LFSR, then appends two directed invalid-opcode vectors (3'b110, 3'b111).
- Captures every Alu response into a 16-bit MISR signature and counts vectors and Invalid responses.
- Sits beside the Alu instance and replaces the simulation-only random bench in silicon and FPGA builds.

Parameters:
- BITS, 4, Alu operand width; legal range 1..12.
- NUM_VECTORS, 100, number of random vectors; legal range 0..65533.
- SETTLE_CYCLES, 1, cycles between driving a vector and sampling the response; legal range 1..15.
- SEED, 32'h0000ACE1, LFSR start value; 0 is replaced by 32'h1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  single-cycle request to run; honoured only in IDLE or DONE.
- A  out  BITS  Alu operand A (registered).
- B  out  BITS  Alu operand B (registered).
- cin, red_op_A, red_op_B, bypass_A, bypass_B  out  1 each  Alu controls (registered).
- opcode  out  3  Alu opcode (registered).
- alu_out  in  BITS+1  Alu Out.
- alu_odd_parity  in  1  Alu Odd_parity.
- alu_invalid  in  1  Alu Invalid.
- busy  out  1  high from the cycle after an accepted start until DONE is entered.
- done  out  1  high while in DONE.
- vec_count  out  16  number of vectors captured.
- invalid_count  out  16  number of captures with alu_invalid=1.
- signature  out  16  MISR value.

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; all Alu-drive outputs 0.
  - busy=0, done=0; counters 0; signature 16'hFFFF; lfsr=SEED.
- States: IDLE, LOAD, WAIT, CAPTURE, DONE.
- IDLE/DONE + start=1:
  - Load lfsr=SEED, signature=16'hFFFF, both counters 0.
  - Go to LOAD; done drops the same edge.
  - start is ignored in all other states.
- LOAD, random phase (vec_count < NUM_VECTORS):
  - Drive fields from the current lfsr: A=lfsr[BITS-1:0], B=lfsr[2B-1:BITS], cin=lfsr[2B], red_op_A=lfsr[2B+1], red_op_B=lfsr[2B+2], bypass_A=lfsr[2B+3], bypass_B=lfsr[2B+4], opcode=lfsr[2B+7:2B+5], where 2B means 2*BITS.
  - Advance the LFSR one step: Fibonacci, polynomial x^32+x^22+x^2+x+1, shift left, feedback into bit 0.
- LOAD, directed phase (vec_count = NUM_VECTORS or NUM_VECTORS+1):
  - Hold A, B, cin, red_op_*, bypass_* at their previous values (all 0 if NUM_VECTORS=0).
  - opcode=3'b110, then 3'b111.
  - LFSR does not advance.
- LOAD -> WAIT: settle counter loads SETTLE_CYCLES-1; WAIT decrements the counter and exits to CAPTURE when it reaches 0.
- CAPTURE:
  - Form d = zero-extended {alu_invalid, alu_odd_parity, alu_out} to 16 bits.
  - signature <= ({sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 0)) ^ d.
  - vec_count += 1; invalid_count += alu_invalid.
  - If the new vec_count = NUM_VECTORS+2, go to DONE; otherwise go to LOAD.
- Timing:
  - Per-vector cost is SETTLE_CYCLES+2 cycles.
  - Total busy cycles = (NUM_VECTORS+2)*(SETTLE_CYCLES+2).
- Alu-drive outputs hold their last value in WAIT, CAPTURE and DONE.
- Counters and signature hold in DONE until the next accepted start.
- rst_n asserted mid-run aborts immediately to the reset state; no partial results are retained.

Test Plan:
- Reset: rst_n=0 with any inputs -> all outputs 0, signature=16'hFFFF, busy=0, done=0; rst_n deasserted without start -> stays IDLE.
- First vector field mapping, BITS=4, SEED=32'h0000ACE1, pulse start -> the cycle after LOAD shows:
  - A=4'h1, B=4'hE, cin=0, red_op_A=0, red_op_B=1, bypass_A=1, bypass_B=0, opcode=3'b101.
- Directed-only run, NUM_VECTORS=0, SETTLE_CYCLES=1, alu_out/alu_odd_parity/alu_invalid tied 0:
  - opcode shows 3'b110 then 3'b111.
  - busy high for exactly 6 cycles, then done=1.
  - vec_count=2, invalid_count=0, signature=16'hCF9F.
- Full run, NUM_VECTORS=4, SETTLE_CYCLES=1, stub Alu (alu_invalid=opcode[2]&opcode[1]):
  - done after 18 busy cycles, vec_count=6.
  - invalid_count = 2 + number of random vectors with opcode 3'b110/3'b111.
  - signature matches the bench model.
- start pulsed while busy -> ignored, no restart; rst_n pulsed low at vector 3 -> IDLE, counters 0, busy=0; a later start runs the full sequence.
- Pulse start again from DONE with an identical stub -> identical vector stream, vec_count, invalid_count and signature (determinism).

Source files
------------

// File: rtl/alu_bist.sv
`default_nettype none
// ============================================================================
// Module   : alu_bist
// Purpose  : Built-in self-test controller for the Alu block. Drives
//            pseudo-random Alu input vectors from a 32-bit Fibonacci LFSR,
//            then two directed invalid-opcode vectors (3'b110, 3'b111).
//            Every Alu response is compacted into a 16-bit MISR signature.
//            Vectors and Invalid responses are counted.
// Ports    : clk, rst_n (async active-low), start (run request)
//            A, B, cin, red_op_A, red_op_B, bypass_A, bypass_B, opcode
//              - registered Alu stimulus
//            alu_out, alu_odd_parity, alu_invalid - Alu response
//            busy, done, vec_count, invalid_count, signature - status/result
// Revision : 1.0 - initial release
// ============================================================================
module alu_bist #(
  parameter int          BITS          = 4,
  parameter int          NUM_VECTORS   = 100,
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [31:0] SEED          = 32'h0000ACE1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [BITS-1:0] A,
  output logic [BITS-1:0] B,
  output logic            cin,
  output logic            red_op_A,
  output logic            red_op_B,
  output logic            bypass_A,
  output logic            bypass_B,
  output logic [2:0]      opcode,
  input  logic [BITS:0]   alu_out,
  input  logic            alu_odd_parity,
  input  logic            alu_invalid,
  output logic            busy,
  output logic            done,
  output logic [15:0]     vec_count,
  output logic [15:0]     invalid_count,
  output logic [15:0]     signature
);

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [31:0] SEED_EFF    = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [15:0] NUM_RAND    = 16'(NUM_VECTORS);
  localparam logic [15:0] NUM_TOTAL   = 16'(NUM_VECTORS + 2);
  localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t      state;
  logic [31:0] lfsr;
  logic [3:0]  settle;

  logic        lfsr_fb;
  logic [16:0] phase_diff;
  logic        random_phase;
  logic [15:0] capture_data;
  logic [15:0] sig_shift;
  logic [15:0] vec_next;

  // x^32 + x^22 + x^2 + x + 1, shifted left with feedback into bit 0.
  assign lfsr_fb      = lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0];

  // Borrow out of (vec_count - NUM_VECTORS) marks the random phase; this
  // stays well-formed even when NUM_VECTORS is 0.
  assign phase_diff   = {1'b0, vec_count} - {1'b0, NUM_RAND};
  assign random_phase = phase_diff[16];

  assign capture_data = 16'({alu_invalid, alu_odd_parity, alu_out});
  assign sig_shift    = {signature[14:0], 1'b0} ^ (signature[15] ? 16'h1021 : 16'h0000);
  assign vec_next     = vec_count + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      lfsr          <= SEED_EFF;
      settle        <= 4'd0;
      A             <= '0;
      B             <= '0;
      cin           <= 1'b0;
      red_op_A      <= 1'b0;
      red_op_B      <= 1'b0;
      bypass_A      <= 1'b0;
      bypass_B      <= 1'b0;
      opcode        <= 3'b000;
      busy          <= 1'b0;
      done          <= 1'b0;
      vec_count     <= 16'd0;
      invalid_count <= 16'd0;
      signature     <= 16'hFFFF;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            lfsr          <= SEED_EFF;
            signature     <= 16'hFFFF;
            vec_count     <= 16'd0;
            invalid_count <= 16'd0;
            busy          <= 1'b1;
            done          <= 1'b0;
            state         <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (random_phase) begin
            A        <= lfsr[BITS-1:0];
            B        <= lfsr[2*BITS-1:BITS];
            cin      <= lfsr[2*BITS];
            red_op_A <= lfsr[2*BITS+1];
            red_op_B <= lfsr[2*BITS+2];
            bypass_A <= lfsr[2*BITS+3];
            bypass_B <= lfsr[2*BITS+4];
            opcode   <= lfsr[2*BITS+7:2*BITS+5];
            lfsr     <= {lfsr[30:0], lfsr_fb};
          end else begin
            // Directed tail: operands/controls hold, only opcode changes.
            opcode <= (vec_count == NUM_RAND) ? 3'b110 : 3'b111;
          end
          settle <= SETTLE_LOAD;
          state  <= S_WAIT;
        end

        S_WAIT: begin
          if (settle == 4'd0) begin
            state <= S_CAPTURE;
          end else begin
            settle <= settle - 4'd1;
          end
        end

        S_CAPTURE: begin
          signature     <= sig_shift ^ capture_data;
          vec_count     <= vec_next;
          invalid_count <= invalid_count + {15'd0, alu_invalid};
          if (vec_next == NUM_TOTAL) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_LOAD;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
